// File: rtl/mem_access_if.sv
// Request/response and d_mem bus bundle for
// the MEM-stage memory-access controller.
interface mem_access_if;
  logic        Start;
  logic        Write;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] LoadData;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  modport master (
    output Start, Write, Size, Unsigned,
    output Address, StoreData, MemReadData,
    input  Busy, Done, Fault, LoadData,
    input  MemAddr, MemWriteData,
    input  MemRead, MemWrite
  );

  modport slave (
    input  Start, Write, Size, Unsigned,
    input  Address, StoreData, MemReadData,
    output Busy, Done, Fault, LoadData,
    output MemAddr, MemWriteData,
    output MemRead, MemWrite
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte-addressed load/store controller for d_mem:
// sub-word extend, read-modify-write, fault checks.
module mem_access_ctrl #(
  parameter int unsigned RAM_WORDS = 256
) (
  input logic        clock,
  input logic        reset,
  mem_access_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, MERGE, WR, DONE
  } state_e;

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [15:0] sdata_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] ldata_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        fault_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_d;
  logic [31:0] merge_d;

  // Reject reserved size, misalignment, out-of-range
  assign fault_d =
    (bus.Size == 2'b11) |
    ((bus.Size == 2'b01) & bus.Address[0]) |
    ((bus.Size == 2'b10) & (|bus.Address[1:0])) |
    ({2'b00, bus.Address[31:2]} >= 32'(RAM_WORDS));

  // Lane select plus sign/zero extension of the read word
  always_comb begin
    byte_v = bus.MemReadData[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? bus.MemReadData[31:16]
                      : bus.MemReadData[15:0];
    ext_d  = bus.MemReadData;
    unique case (size_q)
      2'b00: ext_d = {{24{byte_v[7] & ~uns_q}}, byte_v};
      2'b01: ext_d = {{16{half_v[15] & ~uns_q}}, half_v};
      default: ext_d = bus.MemReadData;
    endcase
  end

  // Old word with the target lane(s) replaced
  always_comb begin
    merge_d = bus.MemReadData;
    if (size_q == 2'b00)
      merge_d[{off_q, 3'b000} +: 8] = sdata_q[7:0];
    else
      merge_d[{off_q[1], 4'b0000} +: 16] = sdata_q;
  end

  // Request FSM with registered strobes and results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      sdata_q <= 16'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ldata_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            write_q <= bus.Write;
            size_q  <= bus.Size;
            uns_q   <= bus.Unsigned;
            off_q   <= bus.Address[1:0];
            sdata_q <= bus.StoreData[15:0];
            addr_q  <= {2'b00, bus.Address[31:2]};
            busy_q  <= 1'b1;
            if (fault_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              if (!bus.Write) ldata_q <= 32'h0;
            end else if (bus.Write && bus.Size == 2'b10) begin
              state_q <= WR;
              wr_q    <= 1'b1;
              wdata_q <= bus.StoreData;
            end else begin
              state_q <= RD;
              rd_q    <= 1'b1;
            end
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          if (write_q) begin
            state_q <= WR;
            wr_q    <= 1'b1;
            wdata_q <= merge_d;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ldata_q <= ext_d;
          end
        end
        MERGE: begin
          state_q <= WR;
          wr_q    <= 1'b1;
        end
        WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Fault        = fault_q;
  assign bus.LoadData     = ldata_q;
  assign bus.MemAddr      = addr_q;
  assign bus.MemWriteData = wdata_q;
  assign bus.MemRead      = rd_q;
  assign bus.MemWrite     = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a
// behavioural d_mem attached.
module tb_mem_access_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:255];

  mem_access_if bus();

  mem_access_ctrl #(.RAM_WORDS(256)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.MemRead && bus.MemAddr < 32'd256)
      bus.MemReadData <= mem[bus.MemAddr[7:0]];
    if (bus.MemWrite && bus.MemAddr < 32'd256)
      mem[bus.MemAddr[7:0]] <= bus.MemWriteData;
  end

  task automatic run_req(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        u,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          dc,
    output logic        flt,
    output int          nrd,
    output int          nwr,
    output logic [31:0] saddr
  );
    dc = -1; flt = 1'b0; nrd = 0; nwr = 0;
    saddr = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.Start = 1'b1; bus.Write = w; bus.Size = sz;
    bus.Unsigned = u; bus.Address = a; bus.StoreData = d;
    @(posedge clock);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.Start = 1'b0;
        bus.Address = 32'h0;
        bus.StoreData = 32'h0;
      end
      if (bus.MemRead) nrd++;
      if (bus.MemWrite) nwr++;
      if (bus.MemRead || bus.MemWrite) saddr = bus.MemAddr;
      if (bus.Done) begin
        dc = k;
        flt = bus.Fault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.Busy, bus.Done, bus.Fault, bus.MemRead, bus.MemWrite}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
        {bus.Busy, bus.Done, bus.Fault, bus.MemRead, bus.MemWrite});
    end
    checks++;
    if (bus.LoadData !== 32'h0 || bus.MemAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0",
        bus.LoadData, bus.MemAddr);
    end
    checks++;
    if (bus.MemWriteData !== 32'h0) begin
      errors++;
      $display("FAIL reset_wdata: got %h expected 0",
        bus.MemWriteData);
    end
    reset = 1'b1;
  endtask

  task automatic test_word();
    int dc, nrd, nwr;
    logic flt;
    logic [31:0] sa;
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF,
      dc, flt, nrd, nwr, sa);
    checks++;
    if (dc !== 1 || nrd !== 0 || nwr !== 1 || sa !== 32'd4) begin
      errors++;
      $display("FAIL sw_timing: got done=%0d rd=%0d wr=%0d addr=%h expected 1 0 1 4",
        dc, nrd, nwr, sa);
    end
    @(negedge clock);
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
      dc, flt, nrd, nwr, sa);
    checks++;
    if (dc !== 2 || nrd !== 1 || nwr !== 0 || sa !== 32'd4) begin
      errors++;
      $display("FAIL lw_timing: got done=%0d rd=%0d wr=%0d addr=%h expected 2 1 0 4",
        dc, nrd, nwr, sa);
    end
    checks++;
    if (bus.LoadData !== 32'hDEADBEEF || flt !== 1'b0) begin
      errors++;
      $display("FAIL lw_data: got %h f=%b expected deadbeef f=0",
        bus.LoadData, flt);
    end
  endtask

  task automatic test_subword_loads();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h7, 32'h7, 32'h6, 32'h4};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080,
                            32'hFFFF80FF, 32'h00007F01};
    int dc, nrd, nwr;
    logic flt;
    logic [31:0] sa;
    mem[1] = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sz[i], un[i], ad[i], 32'h0,
        dc, flt, nrd, nwr, sa);
      checks++;
      if (dc !== 2 || bus.LoadData !== ex[i]) begin
        errors++;
        $display("FAIL subload_%0d: got %h done=%0d expected %h done=2",
          i, bus.LoadData, dc, ex[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    int dc, nrd, nwr;
    logic flt;
    logic [31:0] sa;
    mem[2] = 32'h11223344;
    run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h123456AA,
      dc, flt, nrd, nwr, sa);
    checks++;
    if (dc !== 3 || nrd !== 1 || nwr !== 1 || sa !== 32'd2) begin
      errors++;
      $display("FAIL sb_timing: got done=%0d rd=%0d wr=%0d addr=%h expected 3 1 1 2",
        dc, nrd, nwr, sa);
    end
    @(negedge clock);
    checks++;
    if (mem[2] !== 32'h1122AA44) begin
      errors++;
      $display("FAIL sb_mem: got %h expected 1122aa44", mem[2]);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF,
      dc, flt, nrd, nwr, sa);
    checks++;
    if (dc !== 3 || nrd !== 1 || nwr !== 1) begin
      errors++;
      $display("FAIL sh_timing: got done=%0d rd=%0d wr=%0d expected 3 1 1",
        dc, nrd, nwr);
    end
    @(negedge clock);
    checks++;
    if (mem[2] !== 32'hBEEFAA44) begin
      errors++;
      $display("FAIL sh_mem: got %h expected beefaa44", mem[2]);
    end
    checks++;
    if (bus.LoadData !== 32'h00007F01) begin
      errors++;
      $display("FAIL store_keeps_ld: got %h expected 00007f01",
        bus.LoadData);
    end
  endtask

  task automatic test_faults();
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h3, 32'h6, 32'h0, 32'h400};
    int dc, nrd, nwr;
    logic flt;
    logic [31:0] sa;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
        dc, flt, nrd, nwr, sa);
      run_req(1'b0, sz[i], 1'b0, ad[i], 32'h0,
        dc, flt, nrd, nwr, sa);
      checks++;
      if (dc !== 0 || flt !== 1'b1) begin
        errors++;
        $display("FAIL fault_%0d_flag: got done=%0d f=%b expected 0 1",
          i, dc, flt);
      end
      checks++;
      if (nrd + nwr !== 0) begin
        errors++;
        $display("FAIL fault_%0d_strobes: got %0d expected 0",
          i, nrd + nwr);
      end
      checks++;
      if (bus.LoadData !== 32'h0) begin
        errors++;
        $display("FAIL fault_%0d_ld: got %h expected 0",
          i, bus.LoadData);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] rdm, dnm;
    logic ovl;
    logic [31:0] a2, ld1;
    rdm = '0; dnm = '0; ovl = 1'b0;
    a2 = 32'hFFFF_FFFF; ld1 = 32'h0;
    @(negedge clock);
    bus.Start = 1'b1; bus.Write = 1'b0; bus.Size = 2'b10;
    bus.Unsigned = 1'b0; bus.Address = 32'h10;
    @(posedge clock);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 0) bus.Address = 32'h4;
      if (k == 4) bus.Start = 1'b0;
      rdm[k] = bus.MemRead;
      dnm[k] = bus.Done;
      if (bus.MemRead && bus.MemWrite) ovl = 1'b1;
      if (k == 2) ld1 = bus.LoadData;
      if (k == 4) a2 = bus.MemAddr;
    end
    checks++;
    if (rdm !== 10'b00_0001_0001) begin
      errors++;
      $display("FAIL b2b_reads: got %b expected 0000010001", rdm);
    end
    checks++;
    if (dnm !== 10'b00_0100_0100) begin
      errors++;
      $display("FAIL b2b_done: got %b expected 0001000100", dnm);
    end
    checks++;
    if (ovl !== 1'b0 || a2 !== 32'd1) begin
      errors++;
      $display("FAIL b2b_addr: got ovl=%b addr=%h expected 0 1",
        ovl, a2);
    end
    checks++;
    if (ld1 !== 32'hDEADBEEF || bus.LoadData !== 32'h80FF7F01) begin
      errors++;
      $display("FAIL b2b_data: got %h/%h expected deadbeef/80ff7f01",
        ld1, bus.LoadData);
    end
  endtask

  task automatic test_reset_mid();
    int dc, nrd, nwr, wcnt;
    logic flt;
    logic [31:0] sa;
    mem[3] = 32'h55667788;
    wcnt = 0;
    @(negedge clock);
    bus.Start = 1'b1; bus.Write = 1'b1; bus.Size = 2'b00;
    bus.Address = 32'hC; bus.StoreData = 32'h99;
    @(posedge clock);
    @(negedge clock);
    bus.Start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.MemRead, bus.MemWrite} !== 4'b0 ||
        bus.MemAddr !== 32'h0 || bus.LoadData !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_out: got b=%b a=%h ld=%h expected 0",
        bus.Busy, bus.MemAddr, bus.LoadData);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.MemWrite) wcnt++;
    end
    reset = 1'b1;
    checks++;
    if (wcnt !== 0 || mem[3] !== 32'h55667788) begin
      errors++;
      $display("FAIL rst_mid_mem: got wr=%0d mem=%h expected 0 55667788",
        wcnt, mem[3]);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'hC, 32'h99,
      dc, flt, nrd, nwr, sa);
    @(negedge clock);
    checks++;
    if (dc !== 3 || mem[3] !== 32'h55667799) begin
      errors++;
      $display("FAIL rst_mid_after: got done=%0d mem=%h expected 3 55667799",
        dc, mem[3]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.Start = 1'b0; bus.Write = 1'b0; bus.Size = 2'b00;
    bus.Unsigned = 1'b0; bus.Address = 32'h0;
    bus.StoreData = 32'h0; bus.MemReadData = 32'h0;
    test_reset();
    test_word();
    test_subword_loads();
    test_subword_store();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
